// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between register-file read, the ALU and writeback.
// The ALU takes the slave side; the operand source / result consumer takes the master side.
interface alu_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] tr;
   logic [WIDTH-1:0] sr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dr;
   logic             cf;
   logic             of;
   logic             zf;
   logic             nf;

   modport master (
      output in_valid, op, tr, sr, out_ready,
      input  in_ready, out_valid, dr, cf, of, zf, nf
   );

   modport slave (
      input  in_valid, op, tr, sr, out_ready,
      output in_ready, out_valid, dr, cf, of, zf, nf
   );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and flags; shifts are barrel (SHIFT_ITER=0)
// or one bit per cycle (SHIFT_ITER=1) to allow dropping the barrel shifter.
module alu_pipe #(
   parameter int WIDTH      = 32,
   parameter int SHIFT_ITER = 0
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_CMP = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_NEG = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SLL = 4'd8;
   localparam logic [3:0] OP_SRL = 4'd9;
   localparam logic [3:0] OP_SRA = 4'd10;
   localparam logic [3:0] OP_MOV = 4'd11;
   localparam logic [3:0] OP_LIL = 4'd14;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] dr_q, dr_d;
   logic             cf_q, cf_d, of_q, of_d, zf_q, zf_d, nf_q, nf_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [1:0]       kind_q, kind_d;

   // Single-bit shift step; result is {bit shifted out, shifted value}. kind = op[1:0].
   function automatic logic [WIDTH:0] shift_step(input logic [1:0] kind, input logic [WIDTH-1:0] v);
      case (kind)
         2'b00:   return {v, 1'b0};
         2'b01:   return {v[0], 1'b0, v[WIDTH-1:1]};
         default: return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      endcase
   endfunction

   logic [SHW-1:0]          amt;
   logic                    is_shift, is_nop, accept, iter_start;
   logic [WIDTH:0]          add_w, sub_w, sll_w, srl_w;
   logic signed [WIDTH:0]   sra_w;
   logic [WIDTH:0]          ent_step, run_step;
   logic [WIDTH-1:0]        res;
   logic                    res_cf, res_of, res_zf, res_nf;

   assign amt      = bus.sr[SHW-1:0];
   assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
   assign is_nop   = (bus.op == 4'd12) || (bus.op == 4'd13) || (bus.op == 4'd15);
   assign ent_step = shift_step(bus.op[1:0], bus.tr);
   assign run_step = shift_step(kind_q, work_q);

   assign bus.in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   // Amounts 0 and 1 finish in one cycle even in the iterative build.
   assign iter_start   = (SHIFT_ITER != 0) && is_shift && (amt > SHW'(1));

   always_comb begin
      add_w  = {1'b0, bus.tr} + {1'b0, bus.sr};
      sub_w  = {1'b0, bus.tr} - {1'b0, bus.sr};
      sll_w  = {1'b0, bus.tr} << amt;
      srl_w  = {bus.tr, 1'b0} >> amt;
      sra_w  = $signed({bus.tr, 1'b0}) >>> amt;
      res    = '0;
      res_cf = 1'b0;
      res_of = 1'b0;
      case (bus.op)
         OP_ADD: begin
            res    = add_w[WIDTH-1:0];
            res_cf = add_w[WIDTH];
            res_of = (bus.tr[WIDTH-1] == bus.sr[WIDTH-1]) && (add_w[WIDTH-1] != bus.tr[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res    = sub_w[WIDTH-1:0];
            res_cf = sub_w[WIDTH];
            res_of = (bus.tr[WIDTH-1] != bus.sr[WIDTH-1]) && (sub_w[WIDTH-1] != bus.tr[WIDTH-1]);
         end
         OP_AND: res = bus.tr & bus.sr;
         OP_OR:  res = bus.tr | bus.sr;
         OP_XOR: res = bus.tr ^ bus.sr;
         OP_NOT: res = ~bus.tr;
         OP_NEG: begin
            res    = '0 - bus.tr;
            res_cf = |bus.tr;
            res_of = (bus.tr == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_SLL: begin
            res    = sll_w[WIDTH-1:0];
            res_cf = sll_w[WIDTH];
         end
         OP_SRL: begin
            res    = srl_w[WIDTH:1];
            res_cf = srl_w[0];
         end
         OP_SRA: begin
            res    = sra_w[WIDTH:1];
            res_cf = sra_w[0];
         end
         OP_MOV, OP_LIL: res = bus.sr;
         default: ;
      endcase
      res_zf = (res == '0);
      res_nf = res[WIDTH-1];
      // CMP reports equality in dr/zf but keeps the sign of the difference in nf.
      if (bus.op == OP_CMP) begin
         res    = {{(WIDTH-1){1'b0}}, bus.tr == bus.sr};
         res_zf = (bus.tr == bus.sr);
         res_nf = sub_w[WIDTH-1];
      end else if (is_nop) begin
         res_zf = 1'b0;
         res_nf = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      dr_d        = dr_q;
      cf_d        = cf_q;
      of_d        = of_q;
      zf_d        = zf_q;
      nf_d        = nf_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      kind_d      = kind_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (iter_start) begin
                  state_d     = S_SHIFT;
                  out_valid_d = 1'b0;
                  work_d      = ent_step[WIDTH-1:0];
                  cnt_d       = amt - SHW'(1);
                  kind_d      = bus.op[1:0];
               end else begin
                  out_valid_d = 1'b1;
                  dr_d        = res;
                  cf_d        = res_cf;
                  of_d        = res_of;
                  zf_d        = res_zf;
                  nf_d        = res_nf;
               end
            end else if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         S_SHIFT: begin
            work_d = run_step[WIDTH-1:0];
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b1;
               dr_d        = run_step[WIDTH-1:0];
               cf_d        = run_step[WIDTH];
               of_d        = 1'b0;
               zf_d        = (run_step[WIDTH-1:0] == '0);
               nf_d        = run_step[WIDTH-1];
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         dr_q        <= '0;
         cf_q        <= 1'b0;
         of_q        <= 1'b0;
         zf_q        <= 1'b0;
         nf_q        <= 1'b0;
         cnt_q       <= '0;
         work_q      <= '0;
         kind_q      <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         dr_q        <= dr_d;
         cf_q        <= cf_d;
         of_q        <= of_d;
         zf_q        <= zf_d;
         nf_q        <= nf_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         kind_q      <= kind_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.dr        = dr_q;
   assign bus.cf        = cf_q;
   assign bus.of        = of_q;
   assign bus.zf        = zf_q;
   assign bus.nf        = nf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a barrel-shift instance (b0/dut0) and an iterative-shift instance (b1/dut1).
module tb_alu_pipe;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, CMP = 4'd2, AND_ = 4'd3, XOR_ = 4'd5,
                          NEG = 4'd6, NOT_ = 4'd7, SLL = 4'd8, SRL = 4'd9, SRA = 4'd10,
                          MOV = 4'd11, LD = 4'd12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alu_pipe_if #(.WIDTH(32)) b0 ();
   alu_pipe_if #(.WIDTH(32)) b1 ();

   alu_pipe #(.WIDTH(32), .SHIFT_ITER(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   alu_pipe #(.WIDTH(32), .SHIFT_ITER(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {out_valid, dr, cf, of, zf, nf}
   function automatic logic [63:0] st0();
      return {27'b0, b0.out_valid, b0.dr, b0.cf, b0.of, b0.zf, b0.nf};
   endfunction
   function automatic logic [63:0] st1();
      return {27'b0, b1.out_valid, b1.dr, b1.cf, b1.of, b1.zf, b1.nf};
   endfunction
   function automatic logic [63:0] ex(input logic [31:0] d, input logic [3:0] f);
      return {27'b0, 1'b1, d, f};
   endfunction

   task automatic issue0(input logic [3:0] o, input logic [31:0] t, input logic [31:0] s);
      b0.in_valid = 1'b1; b0.op = o; b0.tr = t; b0.sr = s;
      @(posedge clk); #1;
      b0.in_valid = 1'b0; b0.op = 'x; b0.tr = 'x; b0.sr = 'x;
   endtask

   task automatic issue1(input logic [3:0] o, input logic [31:0] t, input logic [31:0] s);
      b1.in_valid = 1'b1; b1.op = o; b1.tr = t; b1.sr = s;
      @(posedge clk); #1;
      b1.in_valid = 1'b0; b1.op = 'x; b1.tr = 'x; b1.sr = 'x;
   endtask

   // Iterative shift of amount k: busy for k-1 cycles after the accept edge, then result.
   task automatic shift1(input string tag, input logic [3:0] o, input logic [31:0] t,
                         input logic [31:0] s, input int k, input logic [31:0] d, input logic [3:0] f);
      issue1(o, t, s);
      for (int i = 1; i < k; i++) begin
         chk({tag, "_busy"}, {b1.out_valid, b1.in_ready}, 64'h0);
         @(posedge clk); #1;
      end
      chk(tag, st1(), ex(d, f));
   endtask

   initial begin
      int seen;
      b0.in_valid = 1'b0; b0.out_ready = 1'b1; b0.op = '0; b0.tr = '0; b0.sr = '0;
      b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.op = '0; b1.tr = '0; b1.sr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state0", st0(), 64'h0);
      chk("rst_state1", st1(), 64'h0);
      rst = 1'b0;
      chk("rst_ready0", b0.in_ready, 64'h1);
      chk("rst_ready1", b1.in_ready, 64'h1);

      // Arithmetic and logic, flags {cf,of,zf,nf}
      issue0(ADD, 32'h7FFFFFFF, 32'h1); chk("add_ovf",   st0(), ex(32'h80000000, 4'b0101));
      issue0(ADD, 32'hFFFFFFFF, 32'h1); chk("add_carry", st0(), ex(32'h0,        4'b1010));
      issue0(SUB, 32'h3, 32'h5);        chk("sub_borrow",st0(), ex(32'hFFFFFFFE, 4'b1001));
      issue0(CMP, 32'h1234, 32'h1234);  chk("cmp_eq",    st0(), ex(32'h1,        4'b0010));
      issue0(CMP, 32'h2, 32'h3);        chk("cmp_lt",    st0(), ex(32'h0,        4'b1001));
      issue0(NEG, 32'h80000000, 32'h0); chk("neg_min",   st0(), ex(32'h80000000, 4'b1101));
      issue0(NOT_, 32'h0, 32'h0);       chk("not_zero",  st0(), ex(32'hFFFFFFFF, 4'b0001));
      issue0(AND_, 32'hF0F0, 32'h0FF0); chk("and",       st0(), ex(32'h000000F0, 4'b0000));
      issue0(XOR_, 32'hA5, 32'hA5);     chk("xor_zero",  st0(), ex(32'h0,        4'b0010));
      issue0(MOV, 32'h5, 32'h0);        chk("mov_zero",  st0(), ex(32'h0,        4'b0010));
      issue0(LD, 32'h5, 32'h5);         chk("ld_nop",    st0(), ex(32'h0,        4'b0000));
      @(posedge clk); #1;
      chk("retire_idle", b0.out_valid, 64'h0);

      // Barrel shifts
      issue0(SLL, 32'hC0000001, 32'h21); chk("sll1_b",  st0(), ex(32'h80000002, 4'b1001));
      issue0(SRA, 32'h80000000, 32'd31); chk("sra31_b", st0(), ex(32'hFFFFFFFF, 4'b0001));
      issue0(SRL, 32'h1, 32'h0);         chk("srl0_b",  st0(), ex(32'h1,        4'b0000));
      issue0(SRL, 32'h1F, 32'h4);        chk("srl4_b",  st0(), ex(32'h1,        4'b1000));
      issue0(SLL, 32'h20000001, 32'h3);  chk("sll3_b",  st0(), ex(32'h8,        4'b1000));

      // Iterative shifts
      shift1("sll1_i",  SLL, 32'hC0000001, 32'h21, 1,  32'h80000002, 4'b1001);
      shift1("sra31_i", SRA, 32'h80000000, 32'd31, 31, 32'hFFFFFFFF, 4'b0001);
      shift1("srl0_i",  SRL, 32'h1,        32'h0,  0,  32'h1,        4'b0000);
      shift1("srl4_i",  SRL, 32'h1F,       32'h4,  4,  32'h1,        4'b1000);
      shift1("sll3_i",  SLL, 32'h20000001, 32'h3,  3,  32'h8,        4'b1000);
      issue1(SUB, 32'h3, 32'h5);         chk("sub_i",   st1(), ex(32'hFFFFFFFE, 4'b1001));
      @(posedge clk); #1;

      // Backpressure
      b0.out_ready = 1'b0;
      issue0(ADD, 32'h1, 32'h2);
      chk("bp_first", st0(), ex(32'h3, 4'b0000));
      chk("bp_ready_lo", b0.in_ready, 64'h0);
      b0.in_valid = 1'b1; b0.op = ADD; b0.tr = 32'd10; b0.sr = 32'd20;
      @(posedge clk); #1;
      chk("bp_hold1", st0(), ex(32'h3, 4'b0000));
      @(posedge clk); #1;
      chk("bp_hold2", st0(), ex(32'h3, 4'b0000));
      chk("bp_ready_lo2", b0.in_ready, 64'h0);
      b0.out_ready = 1'b1;
      #1;
      chk("bp_ready_hi", b0.in_ready, 64'h1);
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
      chk("bp_second", st0(), ex(32'd30, 4'b0000));

      // Streaming, one result per cycle
      for (int i = 0; i < 8; i++) begin
         b0.in_valid = 1'b1; b0.op = ADD; b0.tr = 32'(i); b0.sr = 32'd100;
         @(posedge clk); #1;
         chk("stream", st0(), ex(32'(i + 100), 4'b0000));
         chk("stream_ready", b0.in_ready, 64'h1);
      end
      b0.in_valid = 1'b0;
      @(posedge clk); #1;

      // Async reset mid-shift and with a held result
      b0.out_ready = 1'b0;
      b0.in_valid = 1'b1; b0.op = ADD; b0.tr = 32'h7FFFFFFF; b0.sr = 32'h1;
      b1.in_valid = 1'b1; b1.op = SRL; b1.tr = 32'hFFFFFFFF; b1.sr = 32'd20;
      @(posedge clk); #1;
      b0.in_valid = 1'b0; b1.in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("mid_shift_busy", {b1.out_valid, b1.in_ready}, 64'h0);
      chk("held_before_rst", st0(), ex(32'h80000000, 4'b0101));
      rst = 1'b1;
      #1;
      chk("async_rst0", st0(), 64'h0);
      chk("async_rst1", st1(), 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      b0.out_ready = 1'b1;
      chk("post_rst_ready1", b1.in_ready, 64'h1);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (b1.out_valid) seen++;
      end
      chk("no_ghost_result", 64'(seen), 64'h0);
      issue1(ADD, 32'h2, 32'h2); chk("add_after_rst1", st1(), ex(32'h4, 4'b0000));
      issue0(ADD, 32'h2, 32'h2); chk("add_after_rst0", st0(), ex(32'h4, 4'b0000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
